// File: rtl/program_loader_memory.sv
// Instruction/data memory with a combinational fetch port and a valid/ready byte-stream loader.
// The cpu is held in reset while the memory is being cleared or loaded.
module program_loader_memory #(
   parameter int unsigned         MEMSIZE  = 16,
   parameter int unsigned         REGSIZE  = 8,
   parameter logic [REGSIZE-1:0]  HLT_WORD = REGSIZE'('hF0)
) (
   input  logic               CLOCK,
   input  logic               RESET,
   input  logic [REGSIZE-1:0] ip,
   output logic [REGSIZE-1:0] memory_ip,
   input  logic               LOAD_START,
   input  logic               LOAD_VALID,
   input  logic [REGSIZE-1:0] LOAD_DATA,
   output logic               LOAD_READY,
   output logic               LOAD_DONE,
   output logic               LOAD_ERROR,
   output logic               CPU_RESET
);

   localparam int unsigned        IW        = $clog2(MEMSIZE);
   localparam int unsigned        AW        = IW + 1;
   localparam logic [AW-1:0]      LAST_ADDR = AW'(MEMSIZE - 1);
   localparam logic [REGSIZE-1:0] MEM_LIMIT = REGSIZE'(MEMSIZE);

   typedef enum logic [2:0] {StClear, StRun, StLen, StData, StFill} state_e;

   state_e             state;
   logic [AW-1:0]      waddr;
   logic [REGSIZE-1:0] remaining;
   logic [REGSIZE-1:0] mem [MEMSIZE];
   logic               we;
   logic [REGSIZE-1:0] wdata;

   always_comb begin
      we    = 1'b0;
      wdata = HLT_WORD;
      if (!RESET) begin
         unique case (state)
            StClear, StFill: we = 1'b1;
            StData: begin
               we    = LOAD_VALID;
               wdata = LOAD_DATA;
            end
            default: we = 1'b0;
         endcase
      end
   end

   always_ff @(posedge CLOCK) begin
      if (we) begin
         mem[waddr[IW-1:0]] <= wdata;
      end
   end

   always_comb begin
      memory_ip = HLT_WORD;
      if (ip < MEM_LIMIT) begin
         memory_ip = mem[ip[IW-1:0]];
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state      <= StClear;
         waddr      <= '0;
         remaining  <= '0;
         LOAD_READY <= 1'b0;
         LOAD_DONE  <= 1'b0;
         LOAD_ERROR <= 1'b0;
         CPU_RESET  <= 1'b1;
      end else begin
         LOAD_DONE <= 1'b0;
         case (state)
            StClear: begin
               waddr <= waddr + 1'b1;
               if (waddr == LAST_ADDR) begin
                  state     <= StRun;
                  CPU_RESET <= 1'b0;
               end
            end
            StRun: begin
               if (LOAD_START) begin
                  state      <= StLen;
                  CPU_RESET  <= 1'b1;
                  LOAD_READY <= 1'b1;
                  LOAD_ERROR <= 1'b0;
               end
            end
            StLen: begin
               if (LOAD_VALID) begin
                  waddr     <= '0;
                  remaining <= LOAD_DATA;
                  if (LOAD_DATA == '0) begin
                     state      <= StFill;
                     LOAD_READY <= 1'b0;
                  end else if (LOAD_DATA > MEM_LIMIT) begin
                     state      <= StClear;
                     LOAD_READY <= 1'b0;
                     LOAD_ERROR <= 1'b1;
                  end else begin
                     state <= StData;
                  end
               end
            end
            StData: begin
               if (LOAD_VALID) begin
                  waddr     <= waddr + 1'b1;
                  remaining <= remaining - 1'b1;
                  if (remaining == REGSIZE'(1)) begin
                     LOAD_READY <= 1'b0;
                     // Last byte landing on the top word means the image was full length.
                     if (waddr == LAST_ADDR) begin
                        state     <= StRun;
                        CPU_RESET <= 1'b0;
                        LOAD_DONE <= 1'b1;
                     end else begin
                        state <= StFill;
                     end
                  end
               end
            end
            StFill: begin
               waddr <= waddr + 1'b1;
               if (waddr == LAST_ADDR) begin
                  state     <= StRun;
                  CPU_RESET <= 1'b0;
                  LOAD_DONE <= 1'b1;
               end
            end
            default: state <= StClear;
         endcase
      end
   end

endmodule
